// File: rtl/mult_issue_ctrl.sv
// Issue stage for a sequential signed multiplier: queues operand pairs, runs one
// start/done handshake at a time, and hands each product to a valid/ready port.
module mult_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int START_HOLD = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_result,
    input  logic                   mul_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_result,
    output logic                   out_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(START_HOLD + 1) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_mem_a [DEPTH];
    logic [WIDTH-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [HW-1:0]     r_hold;
    logic [TW-1:0]     r_tmo;
    logic [WIDTH-1:0]  r_mul_a, r_mul_b;
    logic [2*WIDTH-1:0] r_out_result;
    logic              r_out_valid, r_out_err;
    logic              w_push, w_pop, w_cap, w_abort;

    // in_ready derives from the registered count only, so no pop-to-ready path exists
    assign in_ready   = (r_count < CW'(DEPTH));
    assign w_push     = in_valid & in_ready;
    assign mul_start  = (r_state == S_START);
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_err    = r_out_err;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_cap   = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0 && !r_out_valid) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                // a done level left over from the previous job must drop before moving on
                if (r_hold >= HW'(START_HOLD) && !mul_done) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    w_cap  = 1'b1;
                    w_next = S_OUT;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_abort = 1'b1;
                    w_next  = S_OUT;
                end
            end
            S_OUT: begin
                if (r_out_valid && out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // storage carries no reset; validity is tracked entirely by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= in_a;
            r_mem_b[r_wptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_hold       <= '0;
            r_tmo        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_out_result <= '0;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_mul_a <= r_mem_a[r_rptr];
                r_mul_b <= r_mem_b[r_rptr];
                r_hold  <= '0;
            end

            if (r_state == S_START) begin
                if (w_next == S_WAIT)                 r_tmo  <= '0;
                else if (r_hold < HW'(START_HOLD))    r_hold <= r_hold + HW'(1);
            end

            if (r_state == S_WAIT && !w_cap && !w_abort) r_tmo <= r_tmo + TW'(1);

            if (w_cap) begin
                r_out_result <= mul_result;
                r_out_err    <= 1'b0;
                r_out_valid  <= 1'b1;
            end else if (w_abort) begin
                r_out_result <= '0;
                r_out_err    <= 1'b1;
                r_out_valid  <= 1'b1;
            end else if (r_state == S_OUT && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_err   <= 1'b0;
            end
        end
    end
endmodule
